pop_sequence_controller: RTL and testbench
==========================================

# pop_sequence_controller

Sequences one pulsed-optical-pumping (POP) interrogation run: PUMP, DARK (Ramsey free evolution) and DETECT phases, each lasting a programmable number of timebase ticks, repeated for a programmed number of cycles or indefinitely. It sits downstream of the clock-pulse divider and uses one of its single-cycle pulses (normally `fast_pulse`) as the `tick` timebase. Its 2-bit `phase` output replaces the free-running four-state counter, so phase advance is now controlled rather than fixed-rate. The block drives the pump and detection gate lines directly.

## Interface
Parameters:
- CNT_W, 16, width of the phase length inputs and the internal tick counter
- CYC_W, 8, width of the cycle-count input and the internal cycle counter

Ports:
- clk  in  1  system clock (2.5 MHz)
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  single-clk-cycle timebase enable
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate a run immediately
- pump_len  in  CNT_W  PUMP length in ticks
- dark_len  in  CNT_W  DARK length in ticks
- detect_len  in  CNT_W  DETECT length in ticks
- num_cycles  in  CYC_W  number of cycles; 0 = continuous until abort
- phase  out  2  IDLE=00, PUMP=01, DARK=10, DETECT=11
- pump_on  out  1  high while phase==PUMP
- detect_on  out  1  high while phase==DETECT
- busy  out  1  high while phase!=IDLE
- cycle_done  out  1  one-clk pulse at the end of every DETECT
- seq_done  out  1  one-clk pulse when a finite run completes

## Operation
- All outputs are registered. Reset values: phase=00, all other outputs 0, counters 0.
- IDLE with start=1 and abort=0:
  - Latch pump_len, dark_len, detect_len and num_cycles into shadow registers.
  - Load the tick counter with the PUMP length.
  - Clear the completed-cycle counter.
  - Enter PUMP on the next clk.
- Inputs are not re-sampled during a run.
- Length 0 is treated as 1 tick.
- Tick counting in each non-IDLE phase:
  - A tick with counter > 1 decrements the counter.
  - A tick with counter == 1 ends the phase and the next phase starts on the next clk, with the counter loaded from that phase's length.
  - Only ticks that occur while the phase register holds the phase are counted, so a phase spans exactly N ticks.
- Phase order: PUMP -> DARK -> DETECT.
- End of DETECT:
  - cycle_done=1 for one clk and the completed-cycle counter increments.
  - If num_cycles==0, or the completed count after the increment is less than num_cycles, go to PUMP.
  - Otherwise go to IDLE and assert seq_done in the same clk as cycle_done.
- Continuous mode (num_cycles==0): the completed-cycle counter wraps modulo 2^CYC_W. Wrapping has no effect on sequencing.
- abort=1 in any state:
  - Go to IDLE on the next clk.
  - pump_on, detect_on and busy fall with it.
  - No cycle_done or seq_done is emitted.
  - abort has priority over tick and start in the same clk.
- start while busy is ignored. start held high in IDLE after completion begins a new run on the clk after phase returns to 00.
- tick in IDLE is ignored.
- Asserting rst_n low mid-run forces all reset values immediately; no pulses are emitted.

## Timing
- Latency from start to phase=01 and pump_on=1: 1 clk. The first PUMP tick is the first tick after that edge.
- Phase transition occurs 1 clk after the terminating tick.
- pump_on, detect_on and busy change on the same edge as phase; there is no skew between them.
- cycle_done and seq_done are high for the one clk in which phase leaves DETECT, coincident with the new phase value.
- Throughput is back-to-back: no dead clk or dead tick between cycles.
- Run duration in ticks: num_cycles × (max(pump_len,1) + max(dark_len,1) + max(detect_len,1)).

## Test plan
- Single cycle, tick every 4 clk, lengths 3/2/1, num_cycles=1, start pulse:
  - PUMP spans 3 ticks, DARK 2, DETECT 1.
  - One cycle_done pulse and one seq_done pulse occur on the same clk.
  - busy is low afterwards; total of 6 ticks.
- Three cycles, tick every clk, lengths 2/5/3:
  - cycle_done pulses at clk 10, 20 and 30 after phase=01.
  - seq_done pulses only with the third cycle_done.
  - No IDLE clk between cycles.
- Continuous run, num_cycles=0, lengths 1/1/1, tick every clk, 300 cycles:
  - Sequencing continues across the counter wrap at 256.
  - abort mid-DARK gives phase=00 the next clk and no cycle_done or seq_done.
- Zero lengths 0/0/0, num_cycles=2, tick every clk:
  - Each phase lasts 1 tick and the run ends after 6 ticks.
  - Changing pump_len to 9 mid-run has no effect.
- Simultaneous events:
  - start and abort together in IDLE: the block stays IDLE.
  - abort on the terminating DETECT tick: IDLE with no cycle_done.
  - start during PUMP: ignored.
  - rst_n low during DETECT: all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/pop_sequence_controller.sv
// POP run sequencer: PUMP -> DARK -> DETECT, each N ticks, for num_cycles (0 = forever).
// Outputs registered; phase changes 1 clk after the terminating tick; abort/no backpressure.
module pop_sequence_controller #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pump_len,
    input  logic [CNT_W-1:0] dark_len,
    input  logic [CNT_W-1:0] detect_len,
    input  logic [CYC_W-1:0] num_cycles,
    output logic [1:0]       phase,
    output logic             pump_on,
    output logic             detect_on,
    output logic             busy,
    output logic             cycle_done,
    output logic             seq_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_PUMP   = 2'b01,
        S_DARK   = 2'b10,
        S_DETECT = 2'b11
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CYC_W-1:0] cyc_q;
    logic [CNT_W-1:0] pump_len_q, dark_len_q, detect_len_q;
    logic [CYC_W-1:0] num_cycles_q;
    logic             pump_on_q, detect_on_q, busy_q, cycle_done_q, seq_done_q;
    logic [CYC_W-1:0] cyc_d;
    logic             last_tick;

    // A zero length still occupies one tick.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

    assign cyc_d     = cyc_q + CYC_W'(1);
    assign last_tick = tick && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cyc_q        <= '0;
            pump_len_q   <= '0;
            dark_len_q   <= '0;
            detect_len_q <= '0;
            num_cycles_q <= '0;
            pump_on_q    <= 1'b0;
            detect_on_q  <= 1'b0;
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            cycle_done_q <= 1'b0;
            seq_done_q   <= 1'b0;
            if (abort) begin
                state_q     <= S_IDLE;
                pump_on_q   <= 1'b0;
                detect_on_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            pump_len_q   <= pump_len;
                            dark_len_q   <= dark_len;
                            detect_len_q <= detect_len;
                            num_cycles_q <= num_cycles;
                            cnt_q        <= eff_len(pump_len);
                            cyc_q        <= '0;
                            state_q      <= S_PUMP;
                            pump_on_q    <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                    S_PUMP: begin
                        if (last_tick) begin
                            state_q   <= S_DARK;
                            cnt_q     <= eff_len(dark_len_q);
                            pump_on_q <= 1'b0;
                        end else if (tick) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    S_DARK: begin
                        if (last_tick) begin
                            state_q     <= S_DETECT;
                            cnt_q       <= eff_len(detect_len_q);
                            detect_on_q <= 1'b1;
                        end else if (tick) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    S_DETECT: begin
                        if (last_tick) begin
                            cycle_done_q <= 1'b1;
                            cyc_q        <= cyc_d;
                            detect_on_q  <= 1'b0;
                            // Continuous mode ignores the count, so its wrap is harmless.
                            if (num_cycles_q == '0 || cyc_d < num_cycles_q) begin
                                state_q   <= S_PUMP;
                                cnt_q     <= eff_len(pump_len_q);
                                pump_on_q <= 1'b1;
                            end else begin
                                state_q    <= S_IDLE;
                                busy_q     <= 1'b0;
                                seq_done_q <= 1'b1;
                            end
                        end else if (tick) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign phase      = state_q;
    assign pump_on    = pump_on_q;
    assign detect_on  = detect_on_q;
    assign busy       = busy_q;
    assign cycle_done = cycle_done_q;
    assign seq_done   = seq_done_q;

endmodule

// File: tb/tb_pop_sequence_controller.sv
// Scoreboard bench for pop_sequence_controller: directed runs push expected
// cycle_done/seq_done edges; a negedge monitor pops and compares them.
module tb_pop_sequence_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pump_len = '0;
    logic [15:0] dark_len = '0;
    logic [15:0] detect_len = '0;
    logic [7:0]  num_cycles = '0;
    logic [1:0]  phase;
    logic        pump_on, detect_on, busy, cycle_done, seq_done;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int tick_per = 1;

    typedef struct {
        int at;
        bit seq;
    } exp_t;
    exp_t exp_q[$];

    pop_sequence_controller #(.CNT_W(16), .CYC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start      (start),
        .abort      (abort),
        .pump_len   (pump_len),
        .dark_len   (dark_len),
        .detect_len (detect_len),
        .num_cycles (num_cycles),
        .phase      (phase),
        .pump_on    (pump_on),
        .detect_on  (detect_on),
        .busy       (busy),
        .cycle_done (cycle_done),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Tick is high for edge e when e is a multiple of tick_per.
    always @(posedge clk) begin
        #1;
        tick = ((edge_n + 1) % tick_per) == 0;
    end

    always @(negedge clk) begin
        if (rst_n && (cycle_done || seq_done)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: edge %0d cycle_done=%0b seq_done=%0b, no pulse required",
                         edge_n, cycle_done, seq_done);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (edge_n != e.at || cycle_done !== 1'b1 || seq_done !== e.seq) begin
                    bad++;
                    $display("FAIL pulse: edge %0d cd=%0b sd=%0b, required edge %0d cd=1 sd=%0b",
                             edge_n, cycle_done, seq_done, e.at, e.seq);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic int nth_tick(input int s, input int n, input int per);
        int e = s;
        int c = 0;
        while (c < n) begin
            e++;
            if (e % per == 0) c++;
        end
        return e;
    endfunction

    function automatic int eff(input int l);
        return (l == 0) ? 1 : l;
    endfunction

    task automatic goto_edge(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input int p, input int d, input int t, input int n,
                             input int per, input int nev, output int s);
        int len;
        pump_len   = 16'(p);
        dark_len   = 16'(d);
        detect_len = 16'(t);
        num_cycles = 8'(n);
        tick_per   = per;
        start      = 1'b1;
        s          = edge_n + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_phase", phase, 1);
        check("start_pump_on", pump_on, 1);
        check("start_busy", busy, 1);
        len = eff(p) + eff(d) + eff(t);
        for (int c = 1; c <= nev; c++) begin
            exp_t e;
            e.at  = nth_tick(s, c * len, per);
            e.seq = (n != 0) && (c == n);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("run_ends", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("events_pending", exp_q.size(), 0);
    endtask

    initial begin
        int s;
        #2;
        check("rst_phase", phase, 0);
        check("rst_pump_on", pump_on, 0);
        check("rst_detect_on", detect_on, 0);
        check("rst_busy", busy, 0);
        check("rst_cycle_done", cycle_done, 0);
        check("rst_seq_done", seq_done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single cycle, tick every 4 clk, 3/2/1.
        start_run(3, 2, 1, 1, 4, 1, s);
        goto_edge(nth_tick(s, 2, 4));
        check("t1_pump_after_2", phase, 1);
        goto_edge(nth_tick(s, 3, 4));
        check("t1_dark_after_3", phase, 2);
        check("t1_pump_off", pump_on, 0);
        goto_edge(nth_tick(s, 5, 4));
        check("t1_detect_after_5", phase, 3);
        check("t1_detect_on", detect_on, 1);
        wait_done(100);
        check("t1_idle", phase, 0);

        // Three cycles, tick every clk, 2/5/3: pulses at +10/+20/+30.
        start_run(2, 5, 3, 3, 1, 3, s);
        goto_edge(s + 10);
        check("t2_no_idle_gap", phase, 1);
        goto_edge(s + 20);
        check("t2_no_idle_gap2", phase, 1);
        wait_done(100);

        // Continuous 1/1/1 across the 256 wrap, then abort mid-DARK.
        start_run(1, 1, 1, 0, 1, 300, s);
        goto_edge(s + 901);
        check("t3_dark_before_abort", phase, 2);
        check("t3_busy_before_abort", busy, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("t3_abort_phase", phase, 0);
        check("t3_abort_busy", busy, 0);
        check("t3_abort_pump", pump_on, 0);
        wait_done(10);

        // Zero lengths, two cycles; pump_len change mid-run is ignored.
        start_run(0, 0, 0, 2, 1, 2, s);
        pump_len = 16'd9;
        goto_edge(s + 1);
        check("t4_zero_len_dark", phase, 2);
        wait_done(50);

        // start and abort together in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("t5_start_abort_phase", phase, 0);
        check("t5_start_abort_busy", busy, 0);

        // abort on the terminating DETECT tick.
        start_run(1, 1, 1, 1, 1, 0, s);
        goto_edge(s + 2);
        check("t5_in_detect", phase, 3);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("t5_abort_last_tick", phase, 0);
        wait_done(10);

        // start during PUMP is ignored.
        start_run(3, 1, 1, 1, 1, 1, s);
        start = 1'b1;
        goto_edge(s + 2);
        start = 1'b0;
        check("t5_start_in_pump", phase, 1);
        wait_done(50);

        // Reset during DETECT clears outputs asynchronously.
        start_run(1, 1, 5, 1, 1, 0, s);
        goto_edge(s + 3);
        check("t5_detect_before_rst", phase, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_phase", phase, 0);
        check("t5_rst_detect_on", detect_on, 0);
        check("t5_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_done(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
